// File: rtl/dmem_pkg.sv
// Shared encodings and load formatting for the data-memory responder and writeback stage.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Request attributes held from acceptance until the response is formed
  typedef struct packed {
    logic       we;
    size_e      size;
    logic       uns;
    logic [1:0] lane;
    logic       err;
  } dmem_op_t;

  // Select the addressed lane(s) of a word and sign- or zero-extend to 32 bits
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input size_e       size,
                                              input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = {{24{b[7] & ~uns}}, b};
      SZ_HALF: r = {{16{h[15] & ~uns}}, h};
      SZ_WORD: r = word;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-organised data array with per-byte write enables and a registered read port.
module dmem_byte_ram #(
  parameter  int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  // Zero contents at time 0 in simulation; the array itself is never reset
  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read register doubles as the load holding register
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage data-memory responder: one outstanding request, fixed-latency response.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW         = $clog2(DEPTH_WORDS);
  localparam int unsigned CW         = 4;
  localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;

  state_e      state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  dmem_op_t    op, op_d;
  logic        req_ready_d, rsp_valid_d, rsp_err_d;
  logic [31:0] rsp_rdata_d;

  logic        accept_c, err_c;
  size_e       size_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] ram_rdata;

  assign size_c   = size_e'(req_size);
  assign accept_c = req_ready & req_valid;

  // Illegal size, misalignment and out-of-range detection
  always_comb begin
    err_c = ({1'b0, req_addr} >= BYTE_LIMIT);
    case (size_c)
      SZ_HALF: err_c = err_c | req_addr[0];
      SZ_WORD: err_c = err_c | (req_addr[1:0] != 2'b00);
      SZ_ILL:  err_c = 1'b1;
      default: err_c = err_c;
    endcase
  end

  // Store data is replicated across lanes; enables pick the addressed ones
  always_comb begin
    be_c    = 4'b0000;
    wdata_c = req_wdata;
    case (size_c)
      SZ_BYTE: begin
        be_c    = 4'b0001 << req_addr[1:0];
        wdata_c = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        be_c    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{req_wdata[15:0]}};
      end
      SZ_WORD: be_c = 4'b1111;
      default: be_c = 4'b0000;
    endcase
  end

  dmem_byte_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk  (clk),
    .we   (accept_c & req_we & ~err_c),
    .re   (accept_c & ~req_we & ~err_c),
    .be   (be_c),
    .addr (req_addr[AW+1:2]),
    .wdata(wdata_c),
    .rdata(ram_rdata)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    op_d        = op;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          op_d    = '{we: req_we, size: size_c, uns: req_unsigned,
                      lane: req_addr[1:0], err: err_c};
          cnt_d   = CW'(LATENCY - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          state_d     = ST_RESP;
          rsp_err_d   = op.err;
          rsp_rdata_d = (op.err || op.we) ? '0
                        : load_extend(ram_rdata, op.lane, op.size, op.uns);
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      op        <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      op        <= op_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule
